data_store_buffer: RTL and testbench

In-order store buffer between the MEM-stage pipeline register and the data memory of the 32-bit pipelined MIPS.
- Queues stores from the MEM stage and drains them to memory on cycles when no load owns the single memory port.
- Forwards buffered store data to loads, so loads never see stale memory.
- Owns the memory-side address, write-data and write-enable signals.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/data_store_buffer_fwd.sv | 35 +++
 rtl/data_store_buffer.sv | 130 +++++++++++++
 tb/tb_data_store_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory side: store buffer sizing and entry layout.
package mips_mem_pkg;

  localparam int unsigned SB_WIDTH_DEFAULT = 32;
  localparam int unsigned SB_DEPTH_DEFAULT = 4;

  // One buffered store at the default datapath width.
  typedef struct packed {
    logic [SB_WIDTH_DEFAULT-1:0] addr;
    logic [SB_WIDTH_DEFAULT-1:0] data;
  } sb_entry_t;

  // Pointer width for a buffer of the given depth; never narrower than one bit.
  function automatic int unsigned sb_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_store_buffer_fwd.sv
// Store-to-load forwarding: compares every occupied entry against the load address
// and returns the youngest match.
module data_store_buffer_fwd
  import mips_mem_pkg::*;
#(
  parameter int unsigned WIDTH = SB_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned PtrW  = sb_ptr_width(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] ent_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] ent_data,
  input  logic [PtrW-1:0]             head,
  input  logic [PtrW:0]               count,
  input  logic [WIDTH-1:0]            load_addr,
  output logic                        hit,
  output logic [WIDTH-1:0]            data
);

  logic [PtrW-1:0] idx;

  // Walk entries oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PtrW'(i);
      if ((i < 32'(count)) && (ent_addr[idx] == load_addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/data_store_buffer.sv
// In-order store buffer between the MEM stage and the single-ported data memory.
// Stores queue here and drain oldest-first whenever no load owns the port; loads
// see buffered data through the forwarding network.
module data_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned WIDTH = SB_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                     DataMemory_CLK,
  input  logic                     DataMemory_RST,
  input  logic                     SB_StoreValid,
  input  logic [WIDTH-1:0]         SB_StoreAddr,
  input  logic [WIDTH-1:0]         SB_StoreData,
  output logic                     SB_StoreReady,
  output logic                     SB_Stall,
  input  logic                     SB_LoadValid,
  input  logic [WIDTH-1:0]         SB_LoadAddr,
  output logic [WIDTH-1:0]         SB_LoadData,
  output logic                     SB_LoadHit,
  input  logic                     SB_DrainHold,
  output logic [$clog2(DEPTH):0]   SB_Count,
  output logic                     SB_Empty,
  output logic [WIDTH-1:0]         DataMemory_A,
  output logic [WIDTH-1:0]         DataMemory_WD,
  output logic                     DataMemory_WE,
  input  logic [WIDTH-1:0]         DataMemory_RD
);

  localparam int unsigned PtrW     = sb_ptr_width(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] ent_addr_q;
  logic [DEPTH-1:0][WIDTH-1:0] ent_data_q;
  logic [PtrW-1:0]             head_q, head_d;
  logic [PtrW-1:0]             tail_q, tail_d;
  logic [PtrW:0]               count_q, count_d;

  logic rst_act;
  logic not_full;
  logic drain;
  logic push;
  logic fwd_hit;
  logic [WIDTH-1:0] fwd_data;

  assign rst_act  = !DataMemory_RST;
  assign not_full = (count_q < DepthCnt);

  // A load always owns the port; otherwise a non-empty, unheld buffer drains its head.
  assign drain = !rst_act && !SB_LoadValid && (count_q != '0) && !SB_DrainHold;
  // Acceptance depends on the occupancy at the start of the cycle, not on a same-cycle pop.
  assign push  = !rst_act && SB_StoreValid && not_full && !SB_LoadValid;

  // Handshake and status outputs; reset forces the idle, ready state.
  always_comb begin
    SB_StoreReady = rst_act || (not_full && !SB_LoadValid);
    SB_Stall      = SB_StoreValid && !SB_StoreReady;
    SB_Count      = count_q;
    SB_Empty      = (count_q == '0);
  end

  // Memory port arbitration between the load and the head-of-queue drain.
  always_comb begin
    DataMemory_A  = ent_addr_q[head_q];
    DataMemory_WD = ent_data_q[head_q];
    DataMemory_WE = 1'b0;
    if (rst_act) begin
      DataMemory_A  = '0;
      DataMemory_WD = '0;
    end else if (SB_LoadValid) begin
      DataMemory_A = SB_LoadAddr;
    end else if (drain) begin
      DataMemory_WE = 1'b1;
    end
  end

  data_store_buffer_fwd #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PtrW  (PtrW)
  ) u_fwd (
    .ent_addr  (ent_addr_q),
    .ent_data  (ent_data_q),
    .head      (head_q),
    .count     (count_q),
    .load_addr (SB_LoadAddr),
    .hit       (fwd_hit),
    .data      (fwd_data)
  );

  // Load result: youngest buffered store if one matches, else memory read data.
  always_comb begin
    SB_LoadHit  = !rst_act && SB_LoadValid && fwd_hit;
    SB_LoadData = (SB_LoadValid && fwd_hit) ? fwd_data : DataMemory_RD;
  end

  // Pointer and occupancy next-state for push, pop, or both.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + 1'b1;
    if (push)  tail_d = tail_q + 1'b1;
    unique case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue state; reset discards every buffered store.
  always_ff @(posedge DataMemory_CLK or negedge DataMemory_RST) begin
    if (!DataMemory_RST) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ent_addr_q <= '0;
      ent_data_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        ent_addr_q[tail_q] <= SB_StoreAddr;
        ent_data_q[tail_q] <= SB_StoreData;
      end
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Bench for data_store_buffer: a queue-based model plus a backing memory, checked every cycle.
module tb_data_store_buffer;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sv = 1'b0;
  logic [W-1:0]  sa = '0;
  logic [W-1:0]  sd = '0;
  logic          sready;
  logic          stall;
  logic          lv = 1'b0;
  logic [W-1:0]  la = '0;
  logic [W-1:0]  ldata;
  logic          lhit;
  logic          hold = 1'b0;
  logic [2:0]    cnt;
  logic          empty;
  logic [W-1:0]  mem_a;
  logic [W-1:0]  mem_wd;
  logic          mem_we;
  logic [W-1:0]  mem_rd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } st_t;

  st_t          q[$];
  logic [W-1:0] dmem    [256];
  logic [W-1:0] ref_mem [256];

  always #5 clk = ~clk;

  data_store_buffer #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .DataMemory_CLK (clk),
    .DataMemory_RST (rst_n),
    .SB_StoreValid  (sv),
    .SB_StoreAddr   (sa),
    .SB_StoreData   (sd),
    .SB_StoreReady  (sready),
    .SB_Stall       (stall),
    .SB_LoadValid   (lv),
    .SB_LoadAddr    (la),
    .SB_LoadData    (ldata),
    .SB_LoadHit     (lhit),
    .SB_DrainHold   (hold),
    .SB_Count       (cnt),
    .SB_Empty       (empty),
    .DataMemory_A   (mem_a),
    .DataMemory_WD  (mem_wd),
    .DataMemory_WE  (mem_we),
    .DataMemory_RD  (mem_rd)
  );

  // Memory the DUT actually drives.
  assign mem_rd = dmem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) dmem[mem_a[7:0]] <= mem_wd;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a program-order queue of stores and the memory image they produce.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit can_push = sv && !lv && (q.size() < D);
      automatic bit do_pop   = !lv && (q.size() > 0) && !hold;
      st_t e;
      if (do_pop) begin
        ref_mem[q[0].addr[7:0]] = q[0].data;
        void'(q.pop_front());
      end
      if (can_push) begin
        e.addr = sa;
        e.data = sd;
        q.push_back(e);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic int  n       = q.size();
      automatic bit  e_ready = (n < D) && !lv;
      automatic bit  e_drain = !lv && (n > 0) && !hold;
      automatic bit  e_hit   = 1'b0;
      automatic logic [W-1:0] e_ld = '0;
      chk("count", W'(cnt), W'(n));
      chk("empty", W'(empty), W'(n == 0));
      chk("ready", W'(sready), W'(e_ready));
      chk("stall", W'(stall), W'(sv && !e_ready));
      chk("we", W'(mem_we), W'(e_drain));
      if (e_drain) begin
        chk("drain_a", mem_a, q[0].addr);
        chk("drain_wd", mem_wd, q[0].data);
      end
      if (lv) begin
        e_ld = ref_mem[la[7:0]];
        foreach (q[i]) if (q[i].addr == la) begin
          e_hit = 1'b1;
          e_ld  = q[i].data;
        end
        chk("load_a", mem_a, la);
        chk("load_hit", W'(lhit), W'(e_hit));
        chk("load_data", ldata, e_ld);
      end else begin
        chk("idle_hit", W'(lhit), '0);
        if (n > 0) chk("idle_rd", ldata, ref_mem[q[0].addr[7:0]]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [W-1:0] a, input logic [W-1:0] d);
    sv = 1'b1;
    sa = a;
    sd = d;
    tick();
    sv = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    dmem[8]    = 32'h55;
    ref_mem[8] = 32'h55;

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_count", W'(cnt), 0);
    chk("rst_empty", W'(empty), 1);

    // Single store drains the next cycle.
    store(5, 32'hDEADBEEF);
    #1;
    chk("s1_a", mem_a, 5);
    chk("s1_wd", mem_wd, 32'hDEADBEEF);
    chk("s1_we", W'(mem_we), 1);
    tick();
    chk("s1_empty", W'(empty), 1);
    chk("s1_mem", dmem[5], 32'hDEADBEEF);

    // Fill under hold, reject a fifth store, then drain in order.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) store(W'(i), 32'h100 + W'(i));
    #1;
    chk("full_count", W'(cnt), 4);
    chk("full_ready", W'(sready), 0);
    sv = 1'b1; sa = 9; sd = 32'h999;
    #1;
    chk("full_stall", W'(stall), 1);
    tick();
    sv = 1'b0;
    chk("full_keep", W'(cnt), 4);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("order_we", W'(mem_we), 1);
      chk("order_a", mem_a, W'(i));
      tick();
    end
    chk("order_empty", W'(empty), 1);
    chk("order_mem4", dmem[4], 32'h104);
    chk("no_fifth", dmem[9], 0);

    // Youngest-match forwarding and miss path.
    hold = 1'b1;
    store(7, 1);
    store(7, 2);
    lv = 1'b1; la = 7;
    #1;
    chk("fwd_hit", W'(lhit), 1);
    chk("fwd_data", ldata, 2);
    la = 8;
    #1;
    chk("miss_hit", W'(lhit), 0);
    chk("miss_data", ldata, 32'h55);
    chk("miss_a", mem_a, 8);
    chk("miss_we", W'(mem_we), 0);
    lv = 1'b0; hold = 1'b0;
    tick();
    tick();
    chk("dup_mem", dmem[7], 2);
    chk("dup_empty", W'(empty), 1);

    // Loads block draining; drain resumes when the load drops.
    hold = 1'b1;
    store(32'h10, 32'hA0);
    store(32'h11, 32'hA1);
    hold = 1'b0; lv = 1'b1; la = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_we", W'(mem_we), 0);
      chk("ld_count", W'(cnt), 2);
      tick();
    end
    lv = 1'b0;
    #1;
    chk("resume_we", W'(mem_we), 1);
    chk("resume_a", mem_a, 32'h10);
    tick();
    tick();

    // Simultaneous push and pop at count 1.
    hold = 1'b1;
    store(32'h30, 32'hB0);
    hold = 1'b0;
    sv = 1'b1; sa = 32'h31; sd = 32'hB1;
    #1;
    chk("pp_we", W'(mem_we), 1);
    chk("pp_a", mem_a, 32'h30);
    tick();
    sv = 1'b0;
    chk("pp_count", W'(cnt), 1);
    tick();

    // Streaming through more than 2*DEPTH slots exercises pointer wrap.
    for (int i = 0; i < 2 * D + 1; i++) store(32'h40 + W'(i), 32'hC0 + W'(i));
    tick();
    tick();
    chk("wrap_mem", dmem[8'h48], 32'hC8);

    // Asynchronous reset mid-cycle discards buffered stores.
    hold = 1'b1;
    store(32'h50, 32'hD0);
    store(32'h51, 32'hD1);
    store(32'h52, 32'hD2);
    chk("pre_rst_count", W'(cnt), 3);
    hold = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_count", W'(cnt), 0);
    chk("rst_mid_we", W'(mem_we), 0);
    chk("rst_mid_ready", W'(sready), 1);
    chk("rst_mid_empty", W'(empty), 1);
    chk("rst_mid_a", mem_a, 0);
    chk("rst_mid_wd", mem_wd, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("no_stale", dmem[8'h50], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
